// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver. It synchronises the rx pin, deframes
//               characters with bit-centre sampling, and buffers the bytes in
//               a first-word-fall-through FIFO with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       pop,
  input  logic       clear_err,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       overrun,
  output logic       framing_err
);

  // Clock cycles per bit, and the widths derived from it and from the depth
  localparam int c_div  = CLK_FREQ / BAUD_RATE;
  localparam int c_cw   = $clog2(c_div);
  localparam int c_aw   = $clog2(FIFO_DEPTH);
  localparam int c_cntw = c_aw + 1;

  // Baud reload values: half a bit to reach the start-bit centre, then a full bit
  localparam logic [c_cw-1:0]   c_half  = c_cw'(c_div / 2 - 1);
  localparam logic [c_cw-1:0]   c_full  = c_cw'(c_div - 1);
  localparam logic [c_cntw-1:0] c_depth = c_cntw'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic            r_rx_meta;
  logic            r_rx_s;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_cw-1:0] r_baud;
  logic [c_cw-1:0] w_baud_nxt;
  logic [2:0]      r_bit;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            w_tick;
  logic            w_push;
  logic            w_frame_err;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_cntw-1:0] r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic              w_overrun_set;
  logic              r_overrun;
  logic              r_framing_err;

  // Two-flop synchroniser on the asynchronous pin; idles high out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_baud == '0);

  // Receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic: count to each bit centre and act on the sampled line
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = ST_START;
          w_baud_nxt  = c_half;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_rx_s) begin
            // Line went back high before the start-bit centre: a glitch
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_bit_nxt   = '0;
            w_baud_nxt  = c_full;
          end
        end else begin
          w_baud_nxt = r_baud - c_cw'(1);
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_baud_nxt  = c_full;
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud - c_cw'(1);
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            // Bad stop bit: drop the byte and wait out a held-low line
            w_frame_err = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end else begin
          w_baud_nxt = r_baud - c_cw'(1);
        end
      end
      ST_BREAK: begin
        if (r_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_depth);
  assign w_pop_ok      = pop && !w_empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_push_ok     = w_push && (!w_full || w_pop_ok);
  assign w_overrun_set = w_push && w_full && !w_pop_ok;

  // FIFO storage write port; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cntw'(1);
        2'b01:   r_count <= r_count - c_cntw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new event takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun     <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_err) begin
        r_framing_err <= 1'b1;
      end else if (clear_err) begin
        r_framing_err <= 1'b0;
      end
    end
  end

  assign data_out    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign data_valid  = !w_empty;
  assign fifo_full   = w_full;
  assign overrun     = r_overrun;
  assign framing_err = r_framing_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are scheduled onto a
//               timeline (falling edge -> stop-sample edge) and a queue-based
//               FIFO model is compared with the DUT on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ   = 16;
  localparam int BAUD_RATE  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = CLK_FREQ / BAUD_RATE;
  // Edges from driving the start edge to the stop-sample edge:
  // 2 synchroniser flops + 1 IDLE detect, half a bit, then 9 full bits
  localparam int PUSH_LAT   = 3 + DIV / 2 + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       pop;
  logic       clear_err;
  logic [7:0] data_out;
  logic       data_valid;
  logic       fifo_full;
  logic       overrun;
  logic       framing_err;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .pop        (pop),
    .clear_err  (clear_err),
    .data_out   (data_out),
    .data_valid (data_valid),
    .fifo_full  (fifo_full),
    .overrun    (overrun),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] data;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] m_q[$];
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         chk_on = 1'b0;
  bit         rnd_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: frame outcomes land at their scheduled edge
  always @(posedge clk) begin
    bit         push;
    bit         fe;
    bit         pop_ok;
    bit         was_full;
    logic [7:0] b;
    cyc++;
    push = 1'b0;
    fe   = 1'b0;
    b    = 8'h00;
    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
      if (ev_q[0].good) begin
        push = 1'b1;
        b    = ev_q[0].data;
      end else begin
        fe = 1'b1;
      end
      ev_q.delete(0);
    end
    if (rst) begin
      m_q.delete();
      ev_q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      was_full = (m_q.size() == FIFO_DEPTH);
      pop_ok   = pop && (m_q.size() != 0);
      if (push && was_full && !pop_ok) m_ovr = 1'b1;
      else if (clear_err)              m_ovr = 1'b0;
      if (fe)             m_ferr = 1'b1;
      else if (clear_err) m_ferr = 1'b0;
      if (pop_ok) m_q.delete(0);
      if (push && (!was_full || pop_ok)) m_q.push_back(b);
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (chk_on) begin
      exp_d = (m_q.size() != 0) ? m_q[0] : 8'h00;
      check("data_valid", data_valid, m_q.size() != 0);
      check("data_out", data_out, exp_d);
      check("fifo_full", fifo_full, m_q.size() == FIFO_DEPTH);
      check("overrun", overrun, m_ovr);
      check("framing_err", framing_err, m_ferr);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; the line is left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    ev_t        e;
    bits   = {stop_ok, b, 1'b0};
    e.cyc  = cyc + PUSH_LAT;
    e.good = stop_ok;
    e.data = b;
    ev_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      idle(DIV);
    end
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string nm);
    check(nm, data_out, exp);
    pop = 1'b1;
    idle(1);
    pop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fill [4];
    logic [7:0] pc;
    rst = 1'b1; rx = 1'b1; pop = 1'b0; clear_err = 1'b0;
    idle(3);
    chk_on = 1'b1;
    rst = 1'b0;
    check("rst data_valid", data_valid, 0);
    check("rst data_out", data_out, 8'h00);
    check("rst fifo_full", fifo_full, 0);
    check("rst flags", {overrun, framing_err}, 2'b00);
    idle(4);

    // Single frame: valid appears exactly one cycle after the stop sample
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (PUSH_LAT - 1) @(posedge clk);
        @(negedge clk); check("0x55 valid before stop sample", data_valid, 0);
        @(negedge clk); check("0x55 valid after stop sample", data_valid, 1);
      end
    join
    pop_expect(8'h55, "0x55 head");
    check("0x55 popped valid", data_valid, 0);
    check("0x55 popped data", data_out, 8'h00);
    idle(DIV);

    // Fill, overflow, drain in order
    fill[0] = 8'hA5; fill[1] = 8'h3C; fill[2] = 8'hFF; fill[3] = 8'h00;
    for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1);
    check("fill full", fifo_full, 1);
    check("fill no overrun", overrun, 0);
    send_frame(8'h12, 1'b1);
    check("overflow overrun", overrun, 1);
    for (int i = 0; i < 4; i++) pop_expect(fill[i], "drain order");
    check("drain empty", data_valid, 0);
    pulse_clear();
    check("overrun cleared", overrun, 0);

    // Glitch shorter than half a bit is ignored
    rx = 1'b0; idle(5); rx = 1'b1; idle(2 * DIV);
    check("glitch no push", data_valid, 0);
    send_frame(8'h81, 1'b1);
    pop_expect(8'h81, "after glitch");

    // Bad stop bit then held-low line: one framing error only
    send_frame(8'h7E, 1'b0);
    check("framing set", framing_err, 1);
    idle(50);
    pulse_clear();
    idle(49);
    check("break no second error", framing_err, 0);
    check("break no push", data_valid, 0);
    rx = 1'b1; idle(8);
    send_frame(8'h42, 1'b1);
    pop_expect(8'h42, "after break");

    // Pop on the exact stop-sample edge while full
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (PUSH_LAT - 1) @(posedge clk);
        #1; pop = 1'b1; idle(1); pop = 1'b0;
      end
    join
    check("simul full", fifo_full, 1);
    check("simul no overrun", overrun, 0);
    for (int i = 1; i < 4; i++) pop_expect(fill[i], "simul order");
    pop_expect(8'h99, "simul tail");

    // Reset in DATA bit 3 with two bytes buffered
    send_frame(8'h5A, 1'b1);
    send_frame(8'h6B, 1'b1);
    pc = 8'hC7;
    rx = 1'b0; idle(DIV);
    for (int i = 0; i < 3; i++) begin rx = pc[i]; idle(DIV); end
    rx = pc[3]; idle(DIV / 2);
    rst = 1'b1; rx = 1'b1; idle(2); rst = 1'b0;
    check("mid-frame rst valid", data_valid, 0);
    check("mid-frame rst data", data_out, 8'h00);
    check("mid-frame rst full", fifo_full, 0);
    idle(DIV);
    send_frame(8'hC3, 1'b1);
    pop_expect(8'hC3, "after rst");

    // Randomised traffic with random pops and clears
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          bit ok;
          ok = ($urandom_range(0, 5) != 0);
          send_frame(8'($urandom), ok);
          rx = 1'b1;
          idle($urandom_range(2, 20));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          pop       = ($urandom_range(0, 5) == 0);
          clear_err = ($urandom_range(0, 40) == 0);
          idle(1);
        end
        pop = 1'b0;
        clear_err = 1'b0;
      end
    join
    for (int i = 0; i < FIFO_DEPTH + 1 && data_valid; i++) begin
      pop = 1'b1; idle(1); pop = 1'b0;
    end
    check("final drain", data_valid, 0);
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
